// File: rtl/wb_dma_copy_master_if.sv
// Wishbone classic bundle between the block-copy initiator and the user-area bus.
// Signal names follow the initiator's point of view (_o driven by master, _i driven by slave).
interface wb_dma_copy_master_if;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;

    modport master (
        output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/wb_dma_copy_master.sv
// Wishbone word-copy initiator (READ/RGAP/WRITE/WGAP per word); fill mode under WB_DMA_COPY_FILL_EN.
// Latency: 6*len+2 cycles start-to-done with 1-cycle-ack slaves (3*len+2 in fill mode).
// Backpressure: waits on wbm.ack_i for up to TIMEOUT cycles per access, then aborts with err_o.
module wb_dma_copy_master #(
    parameter int LEN_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 start_i,
    input  logic [31:0]          src_adr_i,
    input  logic [31:0]          dst_adr_i,
    input  logic [LEN_WIDTH-1:0] len_i,
`ifdef WB_DMA_COPY_FILL_EN
    input  logic                 fill_i,
    input  logic [31:0]          fill_data_i,
`endif
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [LEN_WIDTH-1:0] count_o,
    wb_dma_copy_master_if.master wbm
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        RGAP  = 3'd2,
        WRITE = 3'd3,
        WGAP  = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [29:0]          src_q, src_d;
    logic [29:0]          dst_q, dst_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [31:0]          buf_q, buf_d;
    logic [15:0]          tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;

    logic                 fill_mode;
    logic                 start_fill;
    logic                 tmo_hit;
    logic [29:0]          rd_wadr;
    logic [29:0]          wr_wadr;
    logic                 unused_adr_bits;

`ifdef WB_DMA_COPY_FILL_EN
    logic fill_q, fill_d;
    assign fill_mode  = fill_q;
    assign start_fill = fill_i;
`else
    assign fill_mode  = 1'b0;
    assign start_fill = 1'b0;
`endif

    // Byte-offset bits of the operands are dropped; accesses are always word aligned.
    assign unused_adr_bits = ^{src_adr_i[1:0], dst_adr_i[1:0]};

    // The completed-word count doubles as the word index: both advance on each write ack.
    assign rd_wadr = src_q + 30'(count_q);
    assign wr_wadr = dst_q + 30'(count_q);
    assign tmo_hit = ({1'b0, tmo_q} + 17'd1) == 17'(TIMEOUT);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        count_d = count_q;
        buf_d   = buf_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        done_d  = (state_q == FIN);
`ifdef WB_DMA_COPY_FILL_EN
        fill_d  = fill_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d   = src_adr_i[31:2];
                    dst_d   = dst_adr_i[31:2];
                    len_d   = len_i;
                    count_d = '0;
                    err_d   = 1'b0;
                    tmo_d   = '0;
`ifdef WB_DMA_COPY_FILL_EN
                    fill_d  = fill_i;
                    if (fill_i) buf_d = fill_data_i;
`endif
                    if (len_i == '0)     state_d = FIN;
                    else if (start_fill) state_d = WRITE;
                    else                 state_d = READ;
                end
            end
            READ: begin
                if (wbm.ack_i) begin
                    buf_d   = wbm.dat_i;
                    state_d = RGAP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    tmo_d   = tmo_q + 16'd1;
                end
            end
            RGAP: begin
                tmo_d   = '0;
                state_d = WRITE;
            end
            WRITE: begin
                if (wbm.ack_i) begin
                    count_d = count_q + 1'b1;
                    state_d = WGAP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    tmo_d   = tmo_q + 16'd1;
                end
            end
            WGAP: begin
                // The slave's trailing ack lands here and is deliberately ignored.
                tmo_d = '0;
                if (count_q == len_q) state_d = FIN;
                else if (fill_mode)   state_d = WRITE;
                else                  state_d = READ;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef WB_DMA_COPY_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef WB_DMA_COPY_FILL_EN
            fill_q  <= fill_d;
`endif
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign count_o   = count_q;

    assign wbm.cyc_o = (state_q == READ) || (state_q == RGAP) ||
                       (state_q == WRITE) || (state_q == WGAP);
    assign wbm.stb_o = (state_q == READ) || (state_q == WRITE);
    assign wbm.we_o  = (state_q == WRITE);
    assign wbm.sel_o = 4'hF;
    assign wbm.adr_o = (state_q == READ)  ? {rd_wadr, 2'b00} :
                       (state_q == WRITE) ? {wr_wadr, 2'b00} : 32'h0;
    assign wbm.dat_o = (state_q == WRITE) ? buf_q : 32'h0;

endmodule

// File: tb/tb_wb_dma_copy_master.sv
// Directed bench for wb_dma_copy_master with a registered-ack word RAM slave.
module tb_wb_dma_copy_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_adr = '0;
    logic [31:0] dst_adr = '0;
    logic [15:0] len_in = '0;
    logic        busy, done, err;
    logic [15:0] count;
`ifdef WB_DMA_COPY_FILL_EN
    logic        fill_in = 1'b0;
    logic [31:0] fill_dat = '0;
`endif

    wb_dma_copy_master_if wbm();

    wb_dma_copy_master #(.LEN_WIDTH(16), .TIMEOUT(8)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .start_i    (start),
        .src_adr_i  (src_adr),
        .dst_adr_i  (dst_adr),
        .len_i      (len_in),
`ifdef WB_DMA_COPY_FILL_EN
        .fill_i     (fill_in),
        .fill_data_i(fill_dat),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .count_o    (count),
        .wbm        (wbm.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;

    // Slave: 64-word RAM indexed by adr[7:2], ack registered from cyc&stb.
    logic [31:0] mem [0:63];
    logic [31:0] rd_adr [0:7];
    logic        ack = 1'b0;
    logic [31:0] rdat = '0;
    logic        stb_prev = 1'b0;
    int          nrd = 0, nwr = 0, n_acc = 0, n_cyc = 0;
    int          fail_at = -1;
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;

    assign wbm.ack_i = ack;
    assign wbm.dat_i = rdat;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (pl_en) mem[pl_idx] <= pl_dat;
        stb_prev <= wbm.stb_o;
        if (wbm.stb_o && !stb_prev) n_acc <= n_acc + 1;
        if (wbm.cyc_o) n_cyc <= n_cyc + 1;
        if (!rst_n) ack <= 1'b0;
        else        ack <= wbm.cyc_o && wbm.stb_o && !(wbm.we_o && nwr == fail_at);
        rdat <= mem[wbm.adr_o[7:2]];
        if (wbm.cyc_o && wbm.stb_o && ack) begin
            if (wbm.we_o) begin
                mem[wbm.adr_o[7:2]] <= wbm.dat_o;
                nwr <= nwr + 1;
            end else begin
                rd_adr[nrd % 8] <= wbm.adr_o;
                nrd <= nrd + 1;
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_idx = idx[5:0]; pl_dat = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Starts a transfer and returns the start-to-done latency (-1 if done never came).
    // Extra start pulses are injected at relative cycles p1/p2.
    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input int p1, input int p2,
                            output int lat, output logic b1, output logic s1, output logic e1);
        int s;
        lat = -1; b1 = 1'b0; s1 = 1'b0; e1 = 1'b1;
        @(posedge clk); #1;
        src_adr = src; dst_adr = dst; len_in = len[15:0]; start = 1'b1;
        s = cyc_n;
        for (int k = 0; k < 400 && lat < 0; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc_n - s == 1) begin b1 = busy; s1 = wbm.stb_o; e1 = err; end
            if (cyc_n - s == p1 || cyc_n - s == p2) begin
                start = 1'b1; src_adr = 32'h3000_0004; len_in = 16'd1;
            end
            if (done) lat = cyc_n - s;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++; if ({wbm.cyc_o, wbm.stb_o, wbm.we_o} !== 3'b000) begin errors++; $display("FAIL rst_bus got %b exp 000", {wbm.cyc_o, wbm.stb_o, wbm.we_o}); end
        checks++; if (wbm.adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr got %h exp 0", wbm.adr_o); end
        checks++; if (wbm.dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat got %h exp 0", wbm.dat_o); end
        checks++; if (wbm.sel_o !== 4'hF) begin errors++; $display("FAIL rst_sel got %h exp f", wbm.sel_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_copy;
        int lat, r0, w0, a0, c0;
        logic b1, s1, e1;
        logic [31:0] exp_w [0:3];
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
        for (int i = 0; i < 4; i++) preload(i, exp_w[i]);
        r0 = nrd; w0 = nwr; a0 = n_acc; c0 = n_cyc;
        run_xfer(32'h3000_0000, 32'h3000_0040, 4, -1, -1, lat, b1, s1, e1);
        checks++; if (lat != 26) begin errors++; $display("FAIL copy_lat got %0d exp 26", lat); end
        checks++; if ({b1, s1} !== 2'b11) begin errors++; $display("FAIL copy_busy_stb_c1 got %b exp 11", {b1, s1}); end
        checks++; if (count !== 16'd4) begin errors++; $display("FAIL copy_count got %0d exp 4", count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL copy_err got %b exp 0", err); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[16 + i] !== exp_w[i]) begin errors++; $display("FAIL copy_data%0d got %h exp %h", i, mem[16 + i], exp_w[i]); end
        end
        checks++; if (n_acc - a0 != 8) begin errors++; $display("FAIL copy_accesses got %0d exp 8", n_acc - a0); end
        checks++; if (nrd - r0 != 4 || nwr - w0 != 4) begin errors++; $display("FAIL copy_rd_wr got %0d/%0d exp 4/4", nrd - r0, nwr - w0); end
        checks++; if (n_cyc - c0 != 24) begin errors++; $display("FAIL copy_cyc_cycles got %0d exp 24", n_cyc - c0); end
        @(posedge clk); #1;
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL copy_done_pulse got %b exp 00", {done, busy}); end
    endtask

    task automatic test_len_zero;
        int lat, a0, c0;
        logic b1, s1, e1;
        a0 = n_acc; c0 = n_cyc;
        run_xfer(32'h3000_0000, 32'h3000_0040, 0, -1, -1, lat, b1, s1, e1);
        checks++; if (lat != 2) begin errors++; $display("FAIL len0_lat got %0d exp 2", lat); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL len0_busy got %b exp 1", b1); end
        checks++; if (n_cyc - c0 != 0 || n_acc - a0 != 0) begin errors++; $display("FAIL len0_bus got %0d/%0d exp 0/0", n_cyc - c0, n_acc - a0); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL len0_count got %0d exp 0", count); end
    endtask

    task automatic test_timeout;
        int lat;
        logic b1, s1, e1;
        fail_at = nwr + 1;
        run_xfer(32'h3000_0000, 32'h3000_0060, 3, -1, -1, lat, b1, s1, e1);
        checks++; if (lat < 0) begin errors++; $display("FAIL tmo_done got %0d exp pulse", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", err); end
        checks++; if (count !== 16'd1) begin errors++; $display("FAIL tmo_count got %0d exp 1", count); end
        checks++; if (wbm.cyc_o !== 1'b0) begin errors++; $display("FAIL tmo_cyc got %b exp 0", wbm.cyc_o); end
        fail_at = -1;
        @(posedge clk); #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_hold got %b exp 1", err); end
        preload(0, 32'h77);
        run_xfer(32'h3000_0000, 32'h3000_0070, 1, -1, -1, lat, b1, s1, e1);
        checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL tmo_err_clear got %b exp 0", e1); end
        checks++; if (lat != 8) begin errors++; $display("FAIL tmo_good_lat got %0d exp 8", lat); end
        checks++; if ({err, count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL tmo_good_status got %b/%0d exp 0/1", err, count); end
        checks++; if (mem[28] !== 32'h77) begin errors++; $display("FAIL tmo_good_data got %h exp 77", mem[28]); end
    endtask

    task automatic test_reset_midxfer;
        int w0, lat;
        logic b1, s1, e1;
        logic found;
        for (int i = 0; i < 5; i++) preload(8 + i, 32'h5000 + i);
        w0 = nwr;
        found = 1'b0;
        @(posedge clk); #1;
        src_adr = 32'h3000_0020; dst_adr = 32'h3000_00C0; len_in = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (wbm.stb_o && wbm.we_o && nwr - w0 == 1) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_reach_write got %b exp 1", found); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if ({wbm.cyc_o, wbm.stb_o, wbm.we_o, busy, done} !== 5'b0) begin errors++; $display("FAIL rmid_ctrl got %b exp 00000", {wbm.cyc_o, wbm.stb_o, wbm.we_o, busy, done}); end
        checks++; if ({wbm.adr_o, wbm.dat_o} !== 64'h0) begin errors++; $display("FAIL rmid_adr_dat got %h/%h exp 0/0", wbm.adr_o, wbm.dat_o); end
        checks++; if ({err, count} !== 17'h0) begin errors++; $display("FAIL rmid_status got %b/%0d exp 0/0", err, count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL rmid_no_done got %b exp 00", {done, busy}); end
        run_xfer(32'h3000_0020, 32'h3000_00C0, 5, -1, -1, lat, b1, s1, e1);
        checks++; if (lat != 32) begin errors++; $display("FAIL rmid_restart_lat got %0d exp 32", lat); end
        checks++; if (count !== 16'd5) begin errors++; $display("FAIL rmid_restart_count got %0d exp 5", count); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem[48 + i] !== 32'h5000 + i) begin errors++; $display("FAIL rmid_data%0d got %h exp %h", i, mem[48 + i], 32'h5000 + i); end
        end
    endtask

    task automatic test_busy_start_wrap;
        int lat, r0;
        logic b1, s1, e1;
        logic [31:0] exp_a [0:2];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
        preload(62, 32'hA1); preload(63, 32'hA2); preload(0, 32'hA3);
        r0 = nrd;
        // Extra starts: one mid-transfer, one in the FIN cycle (relative cycle 19).
        run_xfer(32'hFFFF_FFF8, 32'h3000_0080, 3, 5, 19, lat, b1, s1, e1);
        checks++; if (lat != 20) begin errors++; $display("FAIL wrap_lat got %0d exp 20", lat); end
        checks++; if (nrd - r0 != 3) begin errors++; $display("FAIL wrap_reads got %0d exp 3", nrd - r0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_adr[(r0 + i) % 8] !== exp_a[i]) begin errors++; $display("FAIL wrap_adr%0d got %h exp %h", i, rd_adr[(r0 + i) % 8], exp_a[i]); end
        end
        checks++; if ({mem[32], mem[33], mem[34]} !== {32'hA1, 32'hA2, 32'hA3}) begin errors++; $display("FAIL wrap_data got %h %h %h exp a1 a2 a3", mem[32], mem[33], mem[34]); end
        checks++; if (count !== 16'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", count); end
        @(posedge clk); #1;
        checks++; if ({busy, wbm.cyc_o} !== 2'b00) begin errors++; $display("FAIL busy_start_ignored got %b exp 00", {busy, wbm.cyc_o}); end
    endtask

`ifdef WB_DMA_COPY_FILL_EN
    task automatic test_fill;
        int lat, r0, w0;
        logic b1, s1, e1;
        r0 = nrd; w0 = nwr;
        fill_in = 1'b1; fill_dat = 32'hA5A5_A5A5;
        run_xfer(32'h3000_0000, 32'h3000_00E0, 3, -1, -1, lat, b1, s1, e1);
        fill_in = 1'b0;
        checks++; if (lat != 11) begin errors++; $display("FAIL fill_lat got %0d exp 11", lat); end
        checks++; if (nrd - r0 != 0 || nwr - w0 != 3) begin errors++; $display("FAIL fill_rd_wr got %0d/%0d exp 0/3", nrd - r0, nwr - w0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem[56 + i] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL fill_data%0d got %h exp a5a5a5a5", i, mem[56 + i]); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_copy;
        test_len_zero;
        test_timeout;
        test_reset_midxfer;
        test_busy_start_wrap;
`ifdef WB_DMA_COPY_FILL_EN
        test_fill;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
